// File: rtl/slave_dev_pkg.sv
// Shared constants and helpers for the multi-channel slave capture device.
// Read-port address map, clog2 and fill-level saturation.
package slave_dev_pkg;

   localparam int ADDR_CNT_HI  = 0;
   localparam int ADDR_CNT_LO  = 1;
   localparam int ADDR_CH_BASE = 2;
   localparam int CH_STRIDE    = 2;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++)
         if ((1 << i) < n) r = i + 1;
      return r;
   endfunction

   function automatic int unsigned sat_level(
      input int unsigned lvl,
      input int unsigned maxv
   );
      return (lvl > maxv) ? maxv : lvl;
   endfunction

endpackage

// File: rtl/sd_chan_fifo.sv
// One producer channel FIFO: wrap-bit pointers, sticky underflow, flush.
// Ports: clk/rst, flush, push+wr_data, pop; level, level_nxt, flags, head.
module sd_chan_fifo
   import slave_dev_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 256,
   localparam int AW    = clog2(DEPTH)
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              push,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              pop,
   output logic [AW:0]       level,
   output logic [AW:0]       level_nxt,
   output logic              full,
   output logic              empty,
   output logic              underflow,
   output logic [DATA_W-1:0] head
);

   logic [AW:0]       wp;
   logic [AW:0]       rp;
   logic [DATA_W-1:0] mem [DEPTH];
   logic              push_en;
   logic              pop_en;

   assign level   = wp - rp;
   assign full    = (level == (AW+1)'(DEPTH));
   assign empty   = (level == '0);
   // flush wins over everything else in the same cycle
   assign push_en = push && !full && !flush;
   assign pop_en  = pop && !empty && !flush;
   assign head    = mem[rp[AW-1:0]];

   always_comb begin
      level_nxt = level;
      if (flush)
         level_nxt = '0;
      else
         level_nxt = level + (AW+1)'(push_en) - (AW+1)'(pop_en);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wp        <= '0;
         rp        <= '0;
         underflow <= 1'b0;
      end else if (flush) begin
         wp        <= '0;
         rp        <= '0;
         underflow <= 1'b0;
      end else begin
         if (push_en) wp <= wp + 1'b1;
         if (pop_en)  rp <= rp + 1'b1;
         if (pop && empty) underflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[wp[AW-1:0]] <= wr_data;
   end

endmodule

// File: rtl/slave_device_mc.sv
// Multi-channel slave capture device: NCH FIFOs drained by one read port.
// Ports: wr_valid/wr_data/wr_ready per channel; rd_rq/rd_addr -> rd_data/rd_valid; new_msg; ready.
module slave_device_mc
   import slave_dev_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 16,
   parameter int NCH    = 2,
   parameter int DEPTH  = 256,
   parameter int THRESH = 1
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NCH-1:0]        wr_valid,
   input  logic [NCH*DATA_W-1:0] wr_data,
   output logic [NCH-1:0]        wr_ready,
   input  logic                  rd_rq,
   input  logic [ADDR_W-1:0]     rd_addr,
   output logic [DATA_W-1:0]     rd_data,
   output logic                  rd_valid,
   input  logic                  new_msg,
   output logic                  ready
);

   localparam int LW  = clog2(DEPTH) + 1;
   localparam int CW  = 2 * DATA_W;
   localparam int unsigned SAT_MAX = 32'((1 << DATA_W) - 1);
   // the underflow flag only fits in the level word when no real level reaches that bit
   localparam bit UF_VIS = (DEPTH < (1 << (DATA_W - 1)));
   localparam logic [DATA_W-1:0] UF_BIT = {1'b1, {(DATA_W-1){1'b0}}};

   logic [LW-1:0]     lvl      [NCH];
   logic [LW-1:0]     lvl_nxt  [NCH];
   logic [DATA_W-1:0] head     [NCH];
   logic [DATA_W-1:0] lvl_word [NCH];
   logic [NCH-1:0]    full;
   logic [NCH-1:0]    empty;
   logic [NCH-1:0]    uf;
   logic [NCH-1:0]    pop_rq;

   logic [CW-1:0]     cnt;
   logic [DATA_W-1:0] latch;
   logic [DATA_W-1:0] rd_mux;
   logic              rdy_nxt;
   logic              hi_rd;

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      assign pop_rq[c] = rd_rq &&
         (rd_addr == ADDR_W'(ADDR_CH_BASE + CH_STRIDE*c + 1));

      sd_chan_fifo #(
         .DATA_W (DATA_W),
         .DEPTH  (DEPTH)
      ) u_fifo (
         .clk       (clk),
         .rst       (rst),
         .flush     (new_msg),
         .push      (wr_valid[c]),
         .wr_data   (wr_data[c*DATA_W +: DATA_W]),
         .pop       (pop_rq[c]),
         .level     (lvl[c]),
         .level_nxt (lvl_nxt[c]),
         .full      (full[c]),
         .empty     (empty[c]),
         .underflow (uf[c]),
         .head      (head[c])
      );

      assign wr_ready[c] = !full[c];
      assign lvl_word[c] =
         DATA_W'(sat_level(32'(lvl[c]), SAT_MAX)) |
         ((UF_VIS && uf[c]) ? UF_BIT : '0);
   end

   assign hi_rd = rd_rq && (rd_addr == ADDR_W'(ADDR_CNT_HI));

   always_comb begin
      rd_mux = '0;
      if (rd_addr == ADDR_W'(ADDR_CNT_HI))
         rd_mux = cnt[CW-1:DATA_W];
      else if (rd_addr == ADDR_W'(ADDR_CNT_LO))
         rd_mux = latch;
      for (int c = 0; c < NCH; c++) begin
         if (rd_addr == ADDR_W'(ADDR_CH_BASE + CH_STRIDE*c))
            rd_mux = lvl_word[c];
         if (rd_addr == ADDR_W'(ADDR_CH_BASE + CH_STRIDE*c + 1))
            rd_mux = empty[c] ? '0 : head[c];
      end
   end

   // ready tracks next-state levels so it lines up with the registered level
   always_comb begin
      rdy_nxt = 1'b0;
      for (int c = 0; c < NCH; c++)
         if (lvl_nxt[c] >= LW'(THRESH)) rdy_nxt = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         latch    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         ready    <= 1'b0;
      end else begin
         rd_valid <= rd_rq;
         ready    <= rdy_nxt;
         if (rd_rq) rd_data <= rd_mux;
         if (new_msg) begin
            cnt   <= '0;
            latch <= '0;
         end else if (hi_rd) begin
            latch <= cnt[DATA_W-1:0];
            cnt   <= cnt + 1'b1;
         end
      end
   end

endmodule
